// File: rtl/rename_alloc.sv
// Dual-dispatch register rename + ROB slot allocator: RAT, circular free list, ROB tail/occupancy.
// Optional RENAME_ZERO_REG_EN: arch r0 hardwired to phys 0, never renamed or freed.
module rename_alloc #(
  parameter int NUM_ARCH  = 32,
  parameter int NUM_PHYS  = 64,
  parameter int ROB_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid_1,
  input  logic                          in_valid_2,
  input  logic                          has_dest_1,
  input  logic                          has_dest_2,
  input  logic [$clog2(NUM_ARCH)-1:0]   dest_arch_1,
  input  logic [$clog2(NUM_ARCH)-1:0]   dest_arch_2,
  input  logic [$clog2(NUM_ARCH)-1:0]   src_a_arch_1,
  input  logic [$clog2(NUM_ARCH)-1:0]   src_b_arch_1,
  input  logic [$clog2(NUM_ARCH)-1:0]   src_a_arch_2,
  input  logic [$clog2(NUM_ARCH)-1:0]   src_b_arch_2,
  output logic                          in_ready,
  output logic                          out_valid_1,
  output logic                          out_valid_2,
  output logic [$clog2(NUM_PHYS)-1:0]   curr_dest_reg_1,
  output logic [$clog2(NUM_PHYS)-1:0]   curr_dest_reg_2,
  output logic [$clog2(NUM_PHYS)-1:0]   old_dest_reg_1,
  output logic [$clog2(NUM_PHYS)-1:0]   old_dest_reg_2,
  output logic [$clog2(ROB_DEPTH)-1:0]  rob_index_1,
  output logic [$clog2(ROB_DEPTH)-1:0]  rob_index_2,
  output logic [$clog2(NUM_PHYS)-1:0]   src_a_phys_1,
  output logic [$clog2(NUM_PHYS)-1:0]   src_b_phys_1,
  output logic [$clog2(NUM_PHYS)-1:0]   src_a_phys_2,
  output logic [$clog2(NUM_PHYS)-1:0]   src_b_phys_2,
  input  logic                          free_valid_1,
  input  logic                          free_valid_2,
  input  logic [$clog2(NUM_PHYS)-1:0]   free_reg_1,
  input  logic [$clog2(NUM_PHYS)-1:0]   free_reg_2,
  input  logic [1:0]                    retire_cnt,
  output logic [$clog2(NUM_PHYS):0]     free_count
);
  localparam int AW = $clog2(NUM_ARCH);
  localparam int PW = $clog2(NUM_PHYS);
  localparam int RW = $clog2(ROB_DEPTH);

  logic [PW-1:0] rat [NUM_ARCH];
  logic [PW-1:0] fl  [NUM_PHYS];
  logic [PW-1:0] fl_head, fl_tail;
  logic [PW:0]   fl_cnt;
  logic [RW-1:0] rob_tail;
  logic [RW:0]   rob_used;

  logic v2, d1, d2, p1, p2, acc, pop1, pop2, push_fits, rt_ok;
  logic [PW-1:0] cur1, cur2, old1, old2, sa2, sb2;
  logic [PW:0]   n_pop, n_push;
  logic [1:0]    rob_need;

  assign v2 = in_valid_2 & in_valid_1;
`ifdef RENAME_ZERO_REG_EN
  assign d1 = has_dest_1 && (dest_arch_1 != '0);
  assign d2 = has_dest_2 && (dest_arch_2 != '0);
  assign p1 = free_valid_1 && (free_reg_1 != '0);
  assign p2 = free_valid_2 && (free_reg_2 != '0);
`else
  assign d1 = has_dest_1;
  assign d2 = has_dest_2;
  assign p1 = free_valid_1;
  assign p2 = free_valid_2;
`endif

  // Worst-case demand (2 regs, 2 slots) keeps ready independent of the request.
  assign in_ready = (fl_cnt >= (PW+1)'(2)) && (rob_used <= (RW+1)'(ROB_DEPTH - 2));
  assign acc      = in_valid_1 & in_ready;
  assign pop1     = acc & d1;
  assign pop2     = acc & v2 & d2;
  assign rob_need = acc ? (v2 ? 2'd2 : 2'd1) : 2'd0;

  assign cur1 = fl[fl_head];
  assign cur2 = fl[fl_head + PW'(pop1)];
  assign old1 = rat[dest_arch_1];
  // Slot 2 sees slot 1's new mapping for the same arch register.
  assign old2 = (d1 && dest_arch_2 == dest_arch_1) ? cur1 : rat[dest_arch_2];
  assign sa2  = (d1 && src_a_arch_2 == dest_arch_1) ? cur1 : rat[src_a_arch_2];
  assign sb2  = (d1 && src_b_arch_2 == dest_arch_1) ? cur1 : rat[src_b_arch_2];

  assign n_pop     = (PW+1)'(pop1) + (PW+1)'(pop2);
  assign n_push    = (PW+1)'(p1) + (PW+1)'(p2);
  assign push_fits = ((PW+2)'(fl_cnt) + (PW+2)'(n_push)) <= ((PW+2)'(NUM_PHYS) + (PW+2)'(n_pop));
  assign rt_ok     = (RW+1)'(retire_cnt) <= rob_used;
  assign free_count = fl_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH; i++) rat[i] <= PW'(i);
      for (int i = 0; i < NUM_PHYS - NUM_ARCH; i++) fl[i] <= PW'(NUM_ARCH + i);
      fl_head  <= '0;
      fl_tail  <= PW'(NUM_PHYS - NUM_ARCH);
      fl_cnt   <= (PW+1)'(NUM_PHYS - NUM_ARCH);
      rob_tail <= '0;
      rob_used <= '0;
      out_valid_1 <= 1'b0;  out_valid_2 <= 1'b0;
      curr_dest_reg_1 <= '0; curr_dest_reg_2 <= '0;
      old_dest_reg_1  <= '0; old_dest_reg_2  <= '0;
      rob_index_1 <= '0;     rob_index_2 <= '0;
      src_a_phys_1 <= '0; src_b_phys_1 <= '0;
      src_a_phys_2 <= '0; src_b_phys_2 <= '0;
    end else begin
      out_valid_1 <= acc;
      out_valid_2 <= acc & v2;
      if (acc) begin
        rob_index_1     <= rob_tail;
        curr_dest_reg_1 <= d1 ? cur1 : '0;
        old_dest_reg_1  <= d1 ? old1 : '0;
        src_a_phys_1    <= rat[src_a_arch_1];
        src_b_phys_1    <= rat[src_b_arch_1];
        if (v2) begin
          rob_index_2     <= rob_tail + RW'(1);
          curr_dest_reg_2 <= d2 ? cur2 : '0;
          old_dest_reg_2  <= d2 ? old2 : '0;
          src_a_phys_2    <= sa2;
          src_b_phys_2    <= sb2;
        end
      end
      if (pop1) rat[dest_arch_1] <= cur1;
      if (pop2) rat[dest_arch_2] <= cur2;

      // Pushes land behind the current tail, so they never feed this cycle's pops.
      if (push_fits) begin
        if (p1) fl[fl_tail] <= free_reg_1;
        if (p2) fl[fl_tail + PW'(p1)] <= free_reg_2;
        fl_tail <= fl_tail + PW'(n_push);
        fl_cnt  <= fl_cnt - n_pop + n_push;
      end else begin
        fl_cnt  <= fl_cnt - n_pop;
      end
      fl_head  <= fl_head + PW'(n_pop);
      rob_tail <= rob_tail + RW'(rob_need);
      rob_used <= rob_used + (RW+1)'(rob_need) - (rt_ok ? (RW+1)'(retire_cnt) : '0);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(in_valid_2 && !in_valid_1));
      assert (rt_ok);
      assert (push_fits);
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = ^{AW[0]};
endmodule

// File: tb/tb_rename_alloc.sv
// Self-checking bench for rename_alloc: directed table, corner sequences, randomized run vs. a queue-based model.
module tb_rename_alloc;
  logic clk = 0, reset = 1;
  logic in_valid_1, in_valid_2, has_dest_1, has_dest_2;
  logic [4:0] dest_arch_1, dest_arch_2, src_a_arch_1, src_b_arch_1, src_a_arch_2, src_b_arch_2;
  logic in_ready, out_valid_1, out_valid_2;
  logic [5:0] curr_dest_reg_1, curr_dest_reg_2, old_dest_reg_1, old_dest_reg_2;
  logic [4:0] rob_index_1, rob_index_2;
  logic [5:0] src_a_phys_1, src_b_phys_1, src_a_phys_2, src_b_phys_2;
  logic free_valid_1, free_valid_2;
  logic [5:0] free_reg_1, free_reg_2;
  logic [1:0] retire_cnt;
  logic [6:0] free_count;

  rename_alloc dut (
    .clk(clk), .reset(reset), .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .has_dest_1(has_dest_1), .has_dest_2(has_dest_2), .dest_arch_1(dest_arch_1), .dest_arch_2(dest_arch_2),
    .src_a_arch_1(src_a_arch_1), .src_b_arch_1(src_b_arch_1), .src_a_arch_2(src_a_arch_2), .src_b_arch_2(src_b_arch_2),
    .in_ready(in_ready), .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .curr_dest_reg_1(curr_dest_reg_1), .curr_dest_reg_2(curr_dest_reg_2),
    .old_dest_reg_1(old_dest_reg_1), .old_dest_reg_2(old_dest_reg_2),
    .rob_index_1(rob_index_1), .rob_index_2(rob_index_2),
    .src_a_phys_1(src_a_phys_1), .src_b_phys_1(src_b_phys_1), .src_a_phys_2(src_a_phys_2), .src_b_phys_2(src_b_phys_2),
    .free_valid_1(free_valid_1), .free_valid_2(free_valid_2), .free_reg_1(free_reg_1), .free_reg_2(free_reg_2),
    .retire_cnt(retire_cnt), .free_count(free_count));

  always #5 clk = ~clk;

  typedef struct {
    bit v1, v2, d1, d2;
    int da1, da2, sa1, sb1, sa2, sb2;
    bit fv1, fv2;
    int fr1, fr2, rc;
  } stim_t;
  typedef struct {
    bit rdy, ov1, ov2, a1, a2;
    int cur1, old1, rob1, sa1, sb1, cur2, old2, rob2, sa2, sb2, fc;
  } exp_t;
  typedef struct { stim_t s; exp_t e; } vec_t;

  int n_cmp = 0, n_bad = 0;
  // Reference state: arch->phys map, free list as a queue, ROB occupancy as plain integers.
  int rat[32];
  int fl[$];
  int olds[$];
  int rob_used, rob_tail;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic stim_t pair(bit v1, bit v2, bit d1, bit d2, int da1, int da2,
                                 int sa1, int sb1, int sa2, int sb2);
    stim_t s;
    s.v1 = v1; s.v2 = v2; s.d1 = d1; s.d2 = d2; s.da1 = da1; s.da2 = da2;
    s.sa1 = sa1; s.sb1 = sb1; s.sa2 = sa2; s.sb2 = sb2;
    s.fv1 = 0; s.fv2 = 0; s.fr1 = 0; s.fr2 = 0; s.rc = 0;
    return s;
  endfunction

  function automatic exp_t ex(bit ov1, int cur1, int old1, int rob1, int sa1, int sb1,
                              bit ov2, int cur2, int old2, int rob2, int sa2, int sb2, int fc);
    exp_t e;
    e.rdy = 1; e.a1 = 0; e.a2 = 0;
    e.ov1 = ov1; e.cur1 = cur1; e.old1 = old1; e.rob1 = rob1; e.sa1 = sa1; e.sb1 = sb1;
    e.ov2 = ov2; e.cur2 = cur2; e.old2 = old2; e.rob2 = rob2; e.sa2 = sa2; e.sb2 = sb2;
    e.fc = fc;
    return e;
  endfunction

  function automatic bit zero_en();
`ifdef RENAME_ZERO_REG_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  function automatic int rd(int a);
    return (zero_en() && a == 0) ? 0 : rat[a];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) rat[i] = i;
    fl.delete(); olds.delete();
    for (int i = 32; i < 64; i++) fl.push_back(i);
    rob_used = 0; rob_tail = 0;
  endfunction

  // Sequential semantics: slot 1 renames fully, then slot 2 sees the updated map.
  function automatic exp_t model(stim_t s);
    exp_t e;
    bit d1, d2, v2;
    e = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e.rdy = (fl.size() >= 2) && (32 - rob_used >= 2);
    v2 = s.v1 && s.v2;
    d1 = s.d1 && !(zero_en() && s.da1 == 0);
    d2 = s.d2 && !(zero_en() && s.da2 == 0);
    if (s.v1 && e.rdy) begin
      e.ov1 = 1; e.rob1 = rob_tail; e.sa1 = rd(s.sa1); e.sb1 = rd(s.sb1);
      if (d1) begin e.a1 = 1; e.old1 = rat[s.da1]; e.cur1 = fl.pop_front(); rat[s.da1] = e.cur1; end
      if (v2) begin
        e.ov2 = 1; e.rob2 = (rob_tail + 1) % 32; e.sa2 = rd(s.sa2); e.sb2 = rd(s.sb2);
        if (d2) begin e.a2 = 1; e.old2 = rat[s.da2]; e.cur2 = fl.pop_front(); rat[s.da2] = e.cur2; end
      end
      rob_tail = (rob_tail + (v2 ? 2 : 1)) % 32;
      rob_used += v2 ? 2 : 1;
    end
    rob_used -= s.rc;
    if (s.fv1 && !(zero_en() && s.fr1 == 0)) fl.push_back(s.fr1);
    if (s.fv2 && !(zero_en() && s.fr2 == 0)) fl.push_back(s.fr2);
    e.fc = fl.size();
    return e;
  endfunction

  task automatic step(input stim_t s, input bit use_t, input exp_t te);
    exp_t e;
    @(negedge clk);
    in_valid_1 = s.v1; in_valid_2 = s.v2; has_dest_1 = s.d1; has_dest_2 = s.d2;
    dest_arch_1 = 5'(s.da1); dest_arch_2 = 5'(s.da2);
    src_a_arch_1 = 5'(s.sa1); src_b_arch_1 = 5'(s.sb1);
    src_a_arch_2 = 5'(s.sa2); src_b_arch_2 = 5'(s.sb2);
    free_valid_1 = s.fv1; free_valid_2 = s.fv2;
    free_reg_1 = 6'(s.fr1); free_reg_2 = 6'(s.fr2); retire_cnt = 2'(s.rc);
    #1;
    e = model(s);
    if (e.a1) olds.push_back(e.old1);
    if (e.a2) olds.push_back(e.old2);
    if (use_t) e = te;
    chk("in_ready", in_ready, e.rdy);
    @(posedge clk); #1;
    chk("out_valid_1", out_valid_1, e.ov1);
    chk("out_valid_2", out_valid_2, e.ov2);
    if (e.ov1) begin
      chk("curr_dest_reg_1", curr_dest_reg_1, e.cur1);
      chk("old_dest_reg_1", old_dest_reg_1, e.old1);
      chk("rob_index_1", rob_index_1, e.rob1);
      chk("src_a_phys_1", src_a_phys_1, e.sa1);
      chk("src_b_phys_1", src_b_phys_1, e.sb1);
    end
    if (e.ov2) begin
      chk("curr_dest_reg_2", curr_dest_reg_2, e.cur2);
      chk("old_dest_reg_2", old_dest_reg_2, e.old2);
      chk("rob_index_2", rob_index_2, e.rob2);
      chk("src_a_phys_2", src_a_phys_2, e.sa2);
      chk("src_b_phys_2", src_b_phys_2, e.sb2);
    end
    chk("free_count", free_count, e.fc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    in_valid_1 = 0; in_valid_2 = 0; has_dest_1 = 0; has_dest_2 = 0;
    free_valid_1 = 0; free_valid_2 = 0; retire_cnt = 0;
    @(posedge clk); #1;
    model_reset();
    chk("rst_valid", {out_valid_1, out_valid_2}, 0);
    chk("rst_dest", {curr_dest_reg_1, curr_dest_reg_2, old_dest_reg_1, old_dest_reg_2}, 0);
    chk("rst_rob", {rob_index_1, rob_index_2}, 0);
    chk("rst_src", {src_a_phys_1, src_b_phys_1, src_a_phys_2, src_b_phys_2}, 0);
    chk("rst_free_count", free_count, 32);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 0;
  endtask

  vec_t tv[7];
  exp_t nx;
  stim_t s;

  initial begin
    int zc;
    zc = zero_en();
    nx = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    {in_valid_1, in_valid_2, has_dest_1, has_dest_2} = '0;
    {dest_arch_1, dest_arch_2, src_a_arch_1, src_b_arch_1, src_a_arch_2, src_b_arch_2} = '0;
    {free_valid_1, free_valid_2, free_reg_1, free_reg_2, retire_cnt} = '0;

    // Directed table from reset, expectations hand-derived.
    tv[0] = '{pair(1,0,1,0, 5,0, 1,2,0,0),  ex(1,32,5,0,1,2, 0,0,0,0,0,0, 31)};
    tv[1] = '{pair(1,1,1,1, 3,3, 5,3,3,5),  ex(1,33,3,1,32,3, 1,34,33,2,33,32, 29)};
    tv[2] = '{pair(1,1,0,1, 0,7, 3,0,3,7),  ex(1,0,0,3,34,0, 1,35,7,4,34,7, 28)};
    tv[3] = '{pair(0,0,0,0, 0,0, 0,0,0,0),  ex(0,0,0,0,0,0, 0,0,0,0,0,0, 30)};
    tv[3].s.fv1 = 1; tv[3].s.fr1 = 5; tv[3].s.fv2 = 1; tv[3].s.fr2 = 7; tv[3].s.rc = 2;
    if (zc != 0) begin
      tv[4] = '{pair(1,0,1,0, 0,0, 0,7,0,0),  ex(1,0,0,5,0,35, 0,0,0,0,0,0, 30)};
      tv[5] = '{pair(1,1,1,1, 9,10, 1,2,9,0), ex(1,36,9,6,1,2, 1,37,10,7,36,0, 28)};
    end else begin
      tv[4] = '{pair(1,0,1,0, 0,0, 0,7,0,0),  ex(1,36,0,5,0,35, 0,0,0,0,0,0, 29)};
      tv[5] = '{pair(1,1,1,1, 9,10, 1,2,9,0), ex(1,37,9,6,1,2, 1,38,10,7,37,36, 27)};
    end
    tv[6] = '{pair(0,0,0,0, 0,0, 0,0,0,0),  ex(0,0,0,0,0,0, 0,0,0,0,0,0, 28)};
    tv[6].s.fv1 = 1; tv[6].s.fr1 = 0;

    do_reset();
    for (int i = 0; i < 7; i++) step(tv[i].s, 1, tv[i].e);

    // Free-list exhaustion: 16 pairs with dests drain it, then frees+retire reopen it.
    do_reset();
    for (int i = 0; i < 16; i++) step(pair(1,1,1,1, 1+i%8, 9+i%8, i,i+1,i+2,i+3), 0, nx);
    chk("fl_empty_count", free_count, 0);
    chk("fl_empty_ready", in_ready, 0);
    s = pair(1,1,1,1, 4,5, 0,0,0,0); s.rc = 2;
    s.fv1 = 1; s.fr1 = olds.pop_front(); s.fv2 = 1; s.fr2 = olds.pop_front();
    step(s, 0, nx);
    chk("fl_stall_nv", out_valid_1, 0);
    #4; chk("fl_reopen_ready", in_ready, 1);

    // ROB exhaustion with no destinations.
    do_reset();
    for (int i = 0; i < 16; i++) step(pair(1,1,0,0, 0,0, i,i,i,i), 0, nx);
    chk("rob_full_ready", in_ready, 0);
    chk("rob_full_count", free_count, 32);
    s = pair(1,0,0,0, 0,0, 0,0,0,0); s.rc = 2;
    step(s, 0, nx);
    #4; chk("rob_reopen_ready", in_ready, 1);

    // Returns at free_count=2 are not bypassed into the same allocation.
    do_reset();
    for (int i = 0; i < 15; i++) step(pair(1,1,1,1, 1,2, 0,0,0,0), 0, nx);
    chk("fc2_count", free_count, 2);
    s = pair(1,1,1,1, 1,2, 0,0,0,0); s.rc = 2; s.fv1 = 1; s.fr1 = 5; s.fv2 = 1; s.fr2 = 7;
    step(s, 0, nx);
    chk("fc2_cur1", curr_dest_reg_1, 62);
    chk("fc2_cur2", curr_dest_reg_2, 63);
    step(pair(1,1,1,1, 3,4, 0,0,0,0), 0, nx);
    chk("fc2_pop5", curr_dest_reg_1, 5);
    chk("fc2_pop7", curr_dest_reg_2, 7);

    // Reset mid-stream.
    do_reset();
    for (int i = 0; i < 10; i++) step(pair(1,1,1,1, i,i+10, 0,0,0,0), 0, nx);
    do_reset();
    step(pair(1,0,1,0, 5,0, 5,6,0,0), 0, nx);
    chk("mid_rst_cur", curr_dest_reg_1, 32);
    chk("mid_rst_old", old_dest_reg_1, 5);
    chk("mid_rst_rob", rob_index_1, 0);
    chk("mid_rst_src", src_b_phys_1, 6);

    // Randomized traffic; frees recycle previously displaced mappings so the list wraps.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      s.v1 = ($urandom_range(0, 9) < 8);
      s.v2 = s.v1 && ($urandom_range(0, 9) < 6);
      s.d1 = ($urandom_range(0, 3) != 0);
      s.d2 = ($urandom_range(0, 3) != 0);
      s.da1 = $urandom_range(0, 31); s.da2 = ($urandom_range(0, 3) == 0) ? s.da1 : $urandom_range(0, 31);
      s.sa1 = $urandom_range(0, 31); s.sb1 = $urandom_range(0, 31);
      s.sa2 = ($urandom_range(0, 2) == 0) ? s.da1 : $urandom_range(0, 31);
      s.sb2 = $urandom_range(0, 31);
      s.rc = $urandom_range(0, (rob_used < 2) ? rob_used : 2);
      s.fv1 = (olds.size() > 0) && ($urandom_range(0, 9) < 4);
      s.fr1 = s.fv1 ? olds.pop_front() : 0;
      s.fv2 = (olds.size() > 0) && ($urandom_range(0, 9) < 4);
      s.fr2 = s.fv2 ? olds.pop_front() : 0;
      step(s, 0, nx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
